// File: rtl/piso_serializer_pkg.sv
// Shared definitions for the parallel-in/serial-out front end:
// FSM state encoding and the bit-counter width helper.
package piso_serializer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  function automatic int cnt_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/piso_serializer.sv
// Serializes a WIDTH-bit word one bit per clock with first/last framing strobes;
// accepts the next word on the last bit so words stream without a bubble.
module piso_serializer
  import piso_serializer_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clock,
  input  logic             clear,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_first,
  output logic             ser_last
);

  localparam int             CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sreg, sreg_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             out_nxt, valid_nxt, first_nxt, last_nxt;
  logic             at_last, accept;

  function automatic logic head_bit(input logic [WIDTH-1:0] w);
    return LSB_FIRST ? w[0] : w[WIDTH-1];
  endfunction

  function automatic logic [WIDTH-1:0] drop_head(input logic [WIDTH-1:0] w);
    return LSB_FIRST ? (w >> 1) : (w << 1);
  endfunction

  assign at_last   = (state == SHIFT) && (cnt == LAST);
  assign din_ready = (state == IDLE) || at_last;
  assign accept    = din_valid && din_ready;

  // The head bit is moved straight into the output register on accept, so
  // cnt always indexes the bit currently presented on ser_out.
  always_comb begin
    state_nxt = state;
    sreg_nxt  = sreg;
    cnt_nxt   = cnt;
    out_nxt   = 1'b0;
    valid_nxt = 1'b0;
    first_nxt = 1'b0;
    last_nxt  = 1'b0;
    if (accept) begin
      state_nxt = SHIFT;
      sreg_nxt  = drop_head(din);
      cnt_nxt   = '0;
      out_nxt   = head_bit(din);
      valid_nxt = 1'b1;
      first_nxt = 1'b1;
    end else if (state == SHIFT) begin
      if (at_last) begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end else begin
        cnt_nxt   = cnt + CNT_W'(1);
        out_nxt   = head_bit(sreg);
        sreg_nxt  = drop_head(sreg);
        valid_nxt = 1'b1;
        last_nxt  = (cnt_nxt == LAST);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!clear) begin
      state     <= IDLE;
      sreg      <= '0;
      cnt       <= '0;
      ser_out   <= 1'b0;
      ser_valid <= 1'b0;
      ser_first <= 1'b0;
      ser_last  <= 1'b0;
    end else begin
      state     <= state_nxt;
      sreg      <= sreg_nxt;
      cnt       <= cnt_nxt;
      ser_out   <= out_nxt;
      ser_valid <= valid_nxt;
      ser_first <= first_nxt;
      ser_last  <= last_nxt;
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: LSB-first and MSB-first instances share stimulus;
// a per-instance queue holds the expected {bit, first, last} stream.
module tb_piso_serializer;

  localparam int W = 8;

  logic         clock = 1'b0;
  logic         clear = 1'b0;
  logic [W-1:0] din = '0;
  logic         din_valid = 1'b0;
  logic [1:0]   rdy, sv, so, sf, sl;

  piso_serializer #(.WIDTH(W), .LSB_FIRST(1'b1)) dut_lsb (
    .clock(clock), .clear(clear), .din(din), .din_valid(din_valid),
    .din_ready(rdy[0]), .ser_out(so[0]), .ser_valid(sv[0]),
    .ser_first(sf[0]), .ser_last(sl[0])
  );

  piso_serializer #(.WIDTH(W), .LSB_FIRST(1'b0)) dut_msb (
    .clock(clock), .clear(clear), .din(din), .din_valid(din_valid),
    .din_ready(rdy[1]), .ser_out(so[1]), .ser_valid(sv[1]),
    .ser_first(sf[1]), .ser_last(sl[1])
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [2:0]   sbq [2][$];
  logic [2:0]   exp_e;
  bit           mon_en = 1'b0;
  int           vcnt = 0;
  int           rdyv = 0;
  logic [W-1:0] cap_l = '0;
  logic [W-1:0] cap_m = '0;

  always @(negedge clock) begin
    if (mon_en) begin
      for (int i = 0; i < 2; i++) begin
        if (sv[i]) begin
          if (sbq[i].size() == 0) begin
            chk($sformatf("extra_bit%0d", i), sbq[i].size(), 1);
          end else begin
            exp_e = sbq[i].pop_front();
            chk($sformatf("stream%0d", i), {so[i], sf[i], sl[i]}, exp_e);
          end
        end else begin
          chk($sformatf("idle_out%0d", i), {so[i], sf[i], sl[i]}, 3'b000);
          chk($sformatf("gap%0d", i), sbq[i].size(), 0);
        end
      end
      if (sv[0]) begin
        vcnt++;
        if (rdy[0]) rdyv++;
        cap_l = {so[0], cap_l[W-1:1]};
      end
      if (sv[1]) cap_m = {cap_m[W-2:0], so[1]};
      if (!clear) begin
        sbq[0].delete();
        sbq[1].delete();
      end else begin
        for (int i = 0; i < 2; i++) begin
          if (din_valid && rdy[i]) begin
            for (int k = 0; k < W; k++) begin
              sbq[i].push_back({(i == 0) ? din[k] : din[W-1-k], k == 0, k == W-1});
            end
          end
        end
      end
    end
  end

  task automatic send(input logic [W-1:0] w);
    int n = 0;
    bit ok = 1'b0;
    din       = w;
    din_valid = 1'b1;
    do begin
      @(negedge clock);
      ok = rdy[0];
      @(posedge clock);
      #1;
      n++;
    end while (!ok && n < 50);
    chk("accept", ok, 1);
    din_valid = 1'b0;
  endtask

  int v0, r0;

  initial begin
    clear     = 1'b0;
    din_valid = 1'b1;
    din       = 8'hA5;
    @(posedge clock); #1;
    mon_en = 1'b1;
    @(posedge clock); #1;
    chk("rst_valid", sv, 0);
    chk("rst_out", so, 0);
    chk("rst_first", sf, 0);
    chk("rst_last", sl, 0);
    clear     = 1'b1;
    din_valid = 1'b0;
    @(negedge clock);
    chk("rst_ready", rdy, 2'b11);
    repeat (3) @(posedge clock);
    #1;
    chk("no_capture", sv, 0);

    v0 = vcnt;
    send(8'h1E);
    repeat (8) @(posedge clock);
    #1;
    chk("w1e_done", sv, 0);
    chk("w1e_len", vcnt - v0, 8);
    chk("w1e_lsb", cap_l, 8'h1E);
    chk("w1e_msb", cap_m, 8'h1E);

    v0 = vcnt;
    r0 = rdyv;
    send(8'h0F);
    send(8'hF0);
    repeat (8) @(posedge clock);
    #1;
    chk("b2b_len", vcnt - v0, 16);
    chk("b2b_rdy", rdyv - r0, 2);
    chk("b2b_lsb", cap_l, 8'hF0);
    chk("b2b_msb", cap_m, 8'hF0);

    send(8'h1E);
    for (int i = 0; i < 7; i++) begin
      din       = (i % 2 == 0) ? 8'h55 : 8'hAA;
      din_valid = 1'b1;
      @(negedge clock);
      chk("busy_rdy", rdy, 2'b00);
      @(posedge clock); #1;
    end
    din = 8'h3C;
    @(negedge clock);
    chk("last_rdy", rdy, 2'b11);
    @(posedge clock); #1;
    din_valid = 1'b0;
    repeat (8) @(posedge clock);
    #1;
    chk("busy_next", cap_l, 8'h3C);
    chk("busy_done", sv, 0);

    send(8'hFF);
    repeat (2) @(posedge clock);
    #1;
    clear = 1'b0;
    @(posedge clock); #1;
    chk("abort_valid", sv, 0);
    chk("abort_last", sl, 0);
    clear = 1'b1;
    v0 = vcnt;
    send(8'h81);
    repeat (8) @(posedge clock);
    #1;
    chk("w81_len", vcnt - v0, 8);
    chk("w81_lsb", cap_l, 8'h81);
    chk("w81_msb", cap_m, 8'h81);

    clear     = 1'b0;
    din       = 8'h77;
    din_valid = 1'b1;
    @(posedge clock); #1;
    clear     = 1'b1;
    din_valid = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_dominates", sv, 0);

    send(8'hC1);
    repeat (8) @(posedge clock);
    #1;
    chk("wc1_msb", cap_m, 8'hC1);
    chk("wc1_lsb", cap_l, 8'hC1);

    repeat (4) @(posedge clock);
    #1;
    chk("drain_lsb", sbq[0].size(), 0);
    chk("drain_msb", sbq[1].size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
